// File: rtl/log2_pkg.sv
// log2_pkg: mode encoding and width helpers shared by the log2 stream unit.
package log2_pkg;
   typedef enum logic [1:0] {
      L2_CEIL  = 2'd0,
      L2_FLOOR = 2'd1,
      L2_CLZ   = 2'd2
   } l2_mode_e;

   function automatic int res_w(input int width);
      return $clog2(width + 1);
   endfunction

   // Code 3 is reserved and behaves as CEIL.
   function automatic l2_mode_e decode_mode(input logic [1:0] mode);
      case (mode)
         2'd1:    return L2_FLOOR;
         2'd2:    return L2_CLZ;
         default: return L2_CEIL;
      endcase
   endfunction
endpackage

// File: rtl/log2_prienc.sv
// log2_prienc: combinational highest-set-bit encoder; idx is 0 when no bit is set.
// No latency, no handshake.
module log2_prienc #(
   parameter int WIDTH = 16,
   parameter int RES_W = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] data,
   output logic [RES_W-1:0] idx,
   output logic             any
);
   always_comb begin
      idx = '0;
      any = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         if (data[i]) begin
            idx = RES_W'(i);
            any = 1'b1;
         end
      end
   end
endmodule

// File: rtl/log2_stream_unit.sv
// log2_stream_unit: streaming ceil/floor-log2 and CLZ, 2-stage pipe (latency 2), saturating ceil-cost total.
// Backpressure: a stalled output freezes S2, S1 fills behind it, then in_ready drops; bubbles collapse.
module log2_stream_unit
   import log2_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int RES_W = res_w(WIDTH),
   parameter int ACC_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [RES_W-1:0] out_result,
   output logic             out_zero,
   output logic [1:0]       out_mode,
   input  logic             acc_en,
   input  logic             acc_clr,
   output logic [ACC_W-1:0] acc_value,
   output logic             acc_sat
);
   typedef struct packed {
      logic             vld;
      logic [1:0]       mode;
      logic [WIDTH-1:0] x;
   } s1_t;

   typedef struct packed {
      logic             vld;
      logic [1:0]       mode;
      logic             zero;
      logic [RES_W-1:0] res;
      logic [RES_W-1:0] cost;
   } s2_t;

   s1_t              s1_q;
   s2_t              s2_q;
   logic             s1_adv, s2_adv;
   logic [WIDTH-1:0] x_m1;
   logic [RES_W-1:0] fl_x, fl_xm1, cost_d, res_d;
   logic             any_x, any_xm1;

   assign s2_adv   = !s2_q.vld || out_ready;
   assign s1_adv   = !s1_q.vld || s2_adv;
   assign in_ready = s1_adv;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_q <= '0;
      end else if (s1_adv) begin
         s1_q.vld <= in_valid;
         if (in_valid) begin
            s1_q.mode <= in_mode;
            s1_q.x    <= in_data;
         end
      end
   end

   assign x_m1 = s1_q.x - WIDTH'(1);

   log2_prienc #(.WIDTH(WIDTH), .RES_W(RES_W)) u_pe_x (
      .data (s1_q.x),
      .idx  (fl_x),
      .any  (any_x)
   );

   log2_prienc #(.WIDTH(WIDTH), .RES_W(RES_W)) u_pe_xm1 (
      .data (x_m1),
      .idx  (fl_xm1),
      .any  (any_xm1)
   );

   // x==0 and x==1 both cost 1 (x-1 has no set bit exactly when x==1).
   always_comb begin
      cost_d = (!any_x || !any_xm1) ? RES_W'(1) : fl_xm1 + RES_W'(1);
      case (decode_mode(s1_q.mode))
         L2_FLOOR: res_d = fl_x;
         L2_CLZ:   res_d = any_x ? RES_W'(WIDTH - 1) - fl_x : RES_W'(WIDTH);
         default:  res_d = cost_d;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s2_q <= '0;
      end else if (s2_adv) begin
         s2_q.vld <= s1_q.vld;
         if (s1_q.vld) begin
            s2_q.mode <= s1_q.mode;
            s2_q.zero <= !any_x;
            s2_q.res  <= res_d;
            s2_q.cost <= cost_d;
         end
      end
   end

   assign out_valid  = s2_q.vld;
   assign out_result = s2_q.res;
   assign out_zero   = s2_q.zero;
   assign out_mode   = s2_q.mode;

   logic [ACC_W-1:0] acc_q, acc_d, acc_base;
   logic             sat_q, sat_d;
   logic [RES_W-1:0] add_c;
   logic [ACC_W:0]   sum;

   // A clear in the same cycle as a transfer restarts the total from that transfer's cost.
   always_comb begin
      acc_base = acc_clr ? '0 : acc_q;
      add_c    = (out_valid && out_ready && acc_en) ? s2_q.cost : '0;
      sum      = {1'b0, acc_base} + (ACC_W + 1)'(add_c);
      acc_d    = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
      sat_d    = (!acc_clr && sat_q) || sum[ACC_W];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q <= '0;
         sat_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         sat_q <= sat_d;
      end
   end

   assign acc_value = acc_q;
   assign acc_sat   = sat_q;
endmodule

// File: tb/tb_log2_stream_unit.sv
// Scoreboard bench: instance A (WIDTH=16, ACC_W=8) for directed cases, instance B (WIDTH=37) for random traffic.
module tb_log2_stream_unit;
   typedef struct {
      int res;
      bit zero;
      int mode;
      int cost;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int a_seen = 0;
   exp_t aq[$];
   exp_t bq[$];

   logic        a_in_valid = 1'b0, a_in_ready;
   logic [15:0] a_in_data = '0;
   logic [1:0]  a_in_mode = '0;
   logic        a_out_valid, a_out_ready = 1'b1;
   logic [4:0]  a_out_result;
   logic        a_out_zero;
   logic [1:0]  a_out_mode;
   logic        a_acc_en = 1'b0, a_acc_clr = 1'b0;
   logic [7:0]  a_acc_value;
   logic        a_acc_sat;

   logic        b_in_valid = 1'b0, b_in_ready;
   logic [36:0] b_in_data = '0;
   logic [1:0]  b_in_mode = '0;
   logic        b_out_valid, b_out_ready = 1'b1;
   logic [5:0]  b_out_result;
   logic        b_out_zero;
   logic [1:0]  b_out_mode;
   logic        b_acc_en = 1'b0, b_acc_clr = 1'b0;
   logic [31:0] b_acc_value;
   logic        b_acc_sat;
   bit          b_rand = 1'b0;

   log2_stream_unit #(.WIDTH(16), .ACC_W(8)) u_a (
      .clk(clk), .rst_n(rst_n),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_mode(a_in_mode),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_result(a_out_result),
      .out_zero(a_out_zero), .out_mode(a_out_mode),
      .acc_en(a_acc_en), .acc_clr(a_acc_clr), .acc_value(a_acc_value), .acc_sat(a_acc_sat)
   );

   log2_stream_unit #(.WIDTH(37), .ACC_W(32)) u_b (
      .clk(clk), .rst_n(rst_n),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_mode(b_in_mode),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_result(b_out_result),
      .out_zero(b_out_zero), .out_mode(b_out_mode),
      .acc_en(b_acc_en), .acc_clr(b_acc_clr), .acc_value(b_acc_value), .acc_sat(b_acc_sat)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: ceil = smallest k with 2^k >= x (min 1), floor by repeated halving.
   function automatic exp_t model(input logic [63:0] x, input int m, input int w);
      exp_t e;
      int fl = 0;
      int cl = 0;
      logic [63:0] t = x;
      while (t > 1) begin
         t = t >> 1;
         fl++;
      end
      while ((64'd1 << cl) < x) cl++;
      if (cl == 0) cl = 1;
      e.cost = cl;
      e.zero = (x == 0);
      e.mode = m;
      case (m)
         1:       e.res = fl;
         2:       e.res = (x == 0) ? w : w - 1 - fl;
         default: e.res = cl;
      endcase
      return e;
   endfunction

   task automatic a_cycle(input logic v, input logic [15:0] x, input logic [1:0] m, output bit took);
      @(negedge clk);
      a_in_valid = v;
      a_in_data  = x;
      a_in_mode  = m;
      #1;
      took = v && a_in_ready;
      if (took) aq.push_back(model(64'(x), int'(m), 16));
   endtask

   task automatic a_idle(input int n);
      bit t;
      for (int i = 0; i < n; i++) a_cycle(1'b0, 16'h0, 2'd0, t);
   endtask

   task automatic a_send(input logic [15:0] x, input logic [1:0] m, output int cyc);
      bit took = 1'b0;
      cyc = 0;
      while (!took && cyc < 100) begin
         a_cycle(1'b1, x, m, took);
         cyc++;
      end
      check("a_accept", took, 1);
   endtask

   task automatic a_drain();
      int n = 0;
      while (aq.size() != 0 && n < 200) begin
         a_idle(1);
         n++;
      end
      check("a_drain", aq.size(), 0);
   endtask

   task automatic b_cycle(input logic v, input logic [36:0] x, input logic [1:0] m, output bit took);
      @(negedge clk);
      b_in_valid = v;
      b_in_data  = x;
      b_in_mode  = m;
      #1;
      took = v && b_in_ready;
      if (took) bq.push_back(model(64'(x), int'(m), 37));
   endtask

   task automatic b_idle(input int n);
      bit t;
      for (int i = 0; i < n; i++) b_cycle(1'b0, 37'h0, 2'd0, t);
   endtask

   task automatic b_send(input logic [36:0] x, input logic [1:0] m, output int cyc);
      bit took = 1'b0;
      cyc = 0;
      while (!took && cyc < 100) begin
         b_cycle(1'b1, x, m, took);
         cyc++;
      end
      check("b_accept", took, 1);
   endtask

   task automatic b_drain();
      int n = 0;
      while (bq.size() != 0 && n < 400) begin
         b_idle(1);
         n++;
      end
      check("b_drain", bq.size(), 0);
   endtask

   function automatic logic [36:0] rand37();
      logic [63:0] r;
      r = {$urandom, $urandom};
      r = r >> $urandom_range(0, 40);
      if ($urandom_range(0, 15) == 0) r = 64'($urandom_range(0, 2));
      return r[36:0];
   endfunction

   initial begin : mon_a
      exp_t e;
      longint acc_m = 0, nxt;
      bit sat_m = 1'b0, hold = 1'b0;
      logic [7:0] h_dat;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            aq.delete();
            acc_m = 0;
            sat_m = 1'b0;
            hold  = 1'b0;
         end else begin
            check("a_acc_value", a_acc_value, acc_m);
            check("a_acc_sat", a_acc_sat, sat_m);
            if (hold) begin
               check("a_hold_valid", a_out_valid, 1);
               check("a_hold_data", {a_out_zero, a_out_mode, a_out_result}, h_dat);
            end
            hold  = a_out_valid && !a_out_ready;
            h_dat = {a_out_zero, a_out_mode, a_out_result};
            nxt   = a_acc_clr ? 0 : acc_m;
            if (a_acc_clr) sat_m = 1'b0;
            if (a_out_valid && a_out_ready) begin
               a_seen++;
               check("a_expected_pending", aq.size() > 0, 1);
               if (aq.size() > 0) begin
                  e = aq.pop_front();
                  check("a_result", a_out_result, e.res);
                  check("a_zero", a_out_zero, e.zero);
                  check("a_mode", a_out_mode, e.mode);
                  if (a_acc_en) nxt += e.cost;
               end
            end
            if (nxt > 255) begin
               nxt   = 255;
               sat_m = 1'b1;
            end
            acc_m = nxt;
         end
      end
   end

   initial begin : mon_b
      exp_t e;
      longint acc_m = 0, nxt;
      bit sat_m = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            bq.delete();
            acc_m = 0;
            sat_m = 1'b0;
         end else begin
            check("b_acc_value", b_acc_value, acc_m);
            check("b_acc_sat", b_acc_sat, sat_m);
            nxt = b_acc_clr ? 0 : acc_m;
            if (b_acc_clr) sat_m = 1'b0;
            if (b_out_valid && b_out_ready) begin
               check("b_expected_pending", bq.size() > 0, 1);
               if (bq.size() > 0) begin
                  e = bq.pop_front();
                  check("b_result", b_out_result, e.res);
                  check("b_zero", b_out_zero, e.zero);
                  check("b_mode", b_out_mode, e.mode);
                  if (b_acc_en) nxt += e.cost;
               end
            end
            if (nxt > 64'hFFFF_FFFF) begin
               nxt   = 64'hFFFF_FFFF;
               sat_m = 1'b1;
            end
            acc_m = nxt;
         end
      end
   end

   always @(negedge clk) begin
      if (b_rand) begin
         b_out_ready = ($urandom_range(0, 3) != 0);
         b_acc_en    = $urandom_range(0, 1) != 0;
         b_acc_clr   = ($urandom_range(0, 19) == 0);
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin : stim
      logic [15:0] ceil_x [7] = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'hFFFF};
      logic [15:0] fl_x [4]   = '{16'd0, 16'd1, 16'h8000, 16'h00F0};
      logic [15:0] bp_x [4]   = '{16'h0011, 16'h0300, 16'h4000, 16'h0007};
      logic [36:0] b_edge [4] = '{37'h1F_FFFF_FFFF, 37'h10_0000_0000, 37'd1, 37'd0};
      int cyc, sum, k, seen0;
      bit t;

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_a_out_valid", a_out_valid, 0);
      check("rst_a_in_ready", a_in_ready, 1);
      check("rst_a_acc", a_acc_value, 0);
      check("rst_a_sat", a_acc_sat, 0);
      check("rst_b_out_valid", b_out_valid, 0);

      a_cycle(1'b1, 16'd5, 2'd0, t);
      check("lat_accept", t, 1);
      a_cycle(1'b0, 16'd0, 2'd0, t);
      check("lat_after_n", a_out_valid, 0);
      a_cycle(1'b0, 16'd0, 2'd0, t);
      check("lat_after_n1", a_out_valid, 1);
      a_drain();

      sum = 0;
      foreach (ceil_x[i]) begin
         a_send(ceil_x[i], 2'd0, cyc);
         sum += cyc;
      end
      check("ceil_stream_cycles", sum, 7);
      a_drain();

      foreach (fl_x[i]) begin
         a_send(fl_x[i], 2'd1, cyc);
         a_send(fl_x[i], 2'd2, cyc);
      end
      a_send(16'h00F0, 2'd3, cyc);
      a_drain();
      a_idle(2);

      a_out_ready = 1'b0;
      k = 0;
      for (int c = 0; c < 5; c++) begin
         a_cycle(1'b1, bp_x[k % 4], 2'd0, t);
         if (t) k++;
      end
      check("bp_accepted_while_stalled", k, 2);
      check("bp_in_ready_low", a_in_ready, 0);
      a_in_valid  = 1'b0;
      a_out_ready = 1'b1;
      for (int i = 2; i < 4; i++) a_send(bp_x[i], 2'd0, cyc);
      a_drain();
      a_idle(2);

      a_acc_clr = 1'b1;
      a_idle(1);
      a_acc_clr = 1'b0;
      a_acc_en  = 1'b1;
      repeat (15) a_send(16'hFFFF, 2'd0, cyc);
      a_drain();
      a_idle(2);
      check("acc_after_15", a_acc_value, 240);
      check("sat_after_15", a_acc_sat, 0);
      repeat (5) a_send(16'hFFFF, 2'd0, cyc);
      a_drain();
      a_idle(2);
      check("acc_after_20", a_acc_value, 255);
      check("sat_after_20", a_acc_sat, 1);

      a_out_ready = 1'b0;
      a_send(16'd4, 2'd0, cyc);
      k = 0;
      while (!a_out_valid && k < 20) begin
         a_idle(1);
         k++;
      end
      check("clr_out_valid", a_out_valid, 1);
      a_acc_clr   = 1'b1;
      a_out_ready = 1'b1;
      a_idle(1);
      a_acc_clr = 1'b0;
      a_idle(1);
      check("clr_acc_value", a_acc_value, 2);
      check("clr_acc_sat", a_acc_sat, 0);

      a_acc_en    = 1'b0;
      a_out_ready = 1'b0;
      a_send(16'd7, 2'd1, cyc);
      a_send(16'd9, 2'd2, cyc);
      a_idle(1);
      check("pre_rst_out_valid", a_out_valid, 1);
      check("pre_rst_in_ready", a_in_ready, 0);
      seen0 = a_seen;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post_rst_out_valid", a_out_valid, 0);
      check("post_rst_in_ready", a_in_ready, 1);
      check("post_rst_acc", a_acc_value, 0);
      a_out_ready = 1'b1;
      a_idle(5);
      check("post_rst_no_stale", a_seen - seen0, 0);

      b_rand = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 9) < 3) b_idle(1);
         else b_send(rand37(), 2'($urandom_range(0, 3)), cyc);
      end
      b_rand      = 1'b0;
      b_out_ready = 1'b1;
      b_acc_clr   = 1'b0;
      b_drain();
      b_idle(2);

      sum = 0;
      for (int i = 0; i < 48; i++) begin
         b_send((i < 12) ? b_edge[i % 4] : rand37(), 2'(i % 4), cyc);
         sum += cyc;
      end
      check("b_throughput_cycles", sum, 48);
      b_drain();
      b_idle(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
